// File: rtl/text_line_scheduler_if.sv
// Write-request bundle for text_line_scheduler: two valid/ready ports,
// A (score text) and B (timer/level text).
interface text_line_scheduler_if;
  logic       reqA_valid;
  logic [3:0] reqA_idx;
  logic [6:0] reqA_char;
  logic       reqA_ready;
  logic       reqB_valid;
  logic [3:0] reqB_idx;
  logic [6:0] reqB_char;
  logic       reqB_ready;

  modport master (
    output reqA_valid, reqA_idx, reqA_char,
    output reqB_valid, reqB_idx, reqB_char,
    input  reqA_ready, reqB_ready
  );

  modport slave (
    input  reqA_valid, reqA_idx, reqA_char,
    input  reqB_valid, reqB_idx, reqB_char,
    output reqA_ready, reqB_ready
  );
endinterface

// File: rtl/text_line_scheduler.sv
// Double-buffered text line with round-robin writers and frame-synced commit.
// Optional macro TEXT_SCALE2_EN draws glyphs at 2x scale.
module text_line_scheduler #(
  parameter int TOP_X     = 16,
  parameter int TOP_Y     = 8,
  parameter int NUM_CHARS = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  text_line_scheduler_if.slave req,
  output logic [6:0]  char_code,
  output logic [2:0]  row_idx,
  output logic [2:0]  col_idx,
  output logic        insideText
);

  localparam logic [6:0] CHAR_NULL = 7'h00;
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] COMMIT    = 1'b1;

`ifdef TEXT_SCALE2_EN
  localparam int SHIFT = 4;
`else
  localparam int SHIFT = 3;
`endif
  localparam int SPAN_X = NUM_CHARS << SHIFT;
  localparam int SPAN_Y = 1 << SHIFT;

  logic [6:0]  shadow [16];
  logic [6:0]  active [16];
  logic [0:0]  state;
  logic        dirty;
  logic        rr_a;
  logic [3:0]  cnt;

  logic        idle_rdy;
  logic        both;
  logic        grant_a;
  logic        grant_b;
  logic        wr_ok;
  logic [3:0]  wr_idx;
  logic [6:0]  wr_char;

  assign idle_rdy = resetN && (state == IDLE);
  assign both     = req.reqA_valid && req.reqB_valid;

  // On contention the port favoured by rr_a wins; the other sees ready=0.
  assign req.reqA_ready = idle_rdy && !(both && !rr_a);
  assign req.reqB_ready = idle_rdy && !(both && rr_a);

  assign grant_a = req.reqA_valid && req.reqA_ready;
  assign grant_b = req.reqB_valid && req.reqB_ready;
  assign wr_idx  = grant_a ? req.reqA_idx : req.reqB_idx;
  assign wr_char = grant_a ? req.reqA_char : req.reqB_char;
  assign wr_ok   = (grant_a || grant_b)
                && ({1'b0, wr_idx} < 5'(NUM_CHARS));

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < 16; i++) begin
        shadow[i] <= CHAR_NULL;
        active[i] <= CHAR_NULL;
      end
      state <= IDLE;
      dirty <= 1'b0;
      rr_a  <= 1'b1;
      cnt   <= 4'd0;
    end else begin
      if (grant_a)
        rr_a <= 1'b0;
      else if (grant_b)
        rr_a <= 1'b1;
      if (wr_ok) begin
        shadow[wr_idx] <= wr_char;
        dirty          <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (startOfFrame && dirty) begin
            state <= COMMIT;
            cnt   <= 4'd0;
          end
        end
        COMMIT: begin
          active[cnt] <= shadow[cnt];
          cnt         <= cnt + 4'd1;
          if (cnt == 4'(NUM_CHARS - 1)) begin
            state <= IDLE;
            dirty <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [11:0] dx;
  logic [11:0] dy;
  logic        in_x;
  logic        in_y;
  logic [3:0]  slot;
  logic [2:0]  col;
  logic [2:0]  row;

  // Compare before subtracting so pixels left/above the line never wrap in.
  always_comb begin
    dx   = {1'b0, pixelX} - 12'(TOP_X);
    dy   = {1'b0, pixelY} - 12'(TOP_Y);
    in_x = ({1'b0, pixelX} >= 12'(TOP_X)) && (dx < 12'(SPAN_X));
    in_y = ({1'b0, pixelY} >= 12'(TOP_Y)) && (dy < 12'(SPAN_Y));
`ifdef TEXT_SCALE2_EN
    slot = dx[7:4];
    col  = dx[3:1];
    row  = dy[3:1];
`else
    slot = dx[6:3];
    col  = dx[2:0];
    row  = dy[2:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      char_code  <= CHAR_NULL;
      row_idx    <= 3'd0;
      col_idx    <= 3'd0;
      insideText <= 1'b0;
    end else if (in_x && in_y) begin
      char_code  <= active[slot];
      row_idx    <= row;
      col_idx    <= col;
      insideText <= 1'b1;
    end else begin
      char_code  <= CHAR_NULL;
      row_idx    <= 3'd0;
      col_idx    <= 3'd0;
      insideText <= 1'b0;
    end
  end

endmodule

// File: tb/tb_text_line_scheduler.sv
// Directed bench for text_line_scheduler: pixel table plus write/commit
// sequences on a 16-slot and an 8-slot instance.
module tb_text_line_scheduler;

  localparam logic [6:0] CH_NUL = 7'h00;
  localparam logic [6:0] CH_A   = 7'h41;
  localparam logic [6:0] CH_B   = 7'h42;
  localparam logic [6:0] CH_C   = 7'h43;
  localparam logic [6:0] CH_E   = 7'h45;
  localparam logic [6:0] CH_F   = 7'h46;
  localparam logic [6:0] CH_Q   = 7'h51;
  localparam logic [6:0] CH_Z   = 7'h5A;
  localparam logic [6:0] CH_5   = 7'h35;
  localparam int TX = 16;
  localparam int TY = 8;

  logic        clk = 1'b0;
  logic        resetN;
  logic        sof0;
  logic        sof1;
  logic [10:0] px;
  logic [10:0] py;
  logic [6:0]  code0;
  logic [2:0]  row0;
  logic [2:0]  col0;
  logic        ins0;
  logic [6:0]  code1;
  logic [2:0]  row1;
  logic [2:0]  col1;
  logic        ins1;

  int n_total = 0;
  int n_pass  = 0;

  text_line_scheduler_if ifa ();
  text_line_scheduler_if ifb ();

  always #5 clk = ~clk;

  text_line_scheduler #(.TOP_X(TX), .TOP_Y(TY), .NUM_CHARS(16)) u0 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof0),
    .pixelX(px), .pixelY(py), .req(ifa),
    .char_code(code0), .row_idx(row0), .col_idx(col0),
    .insideText(ins0)
  );

  text_line_scheduler #(.TOP_X(TX), .TOP_Y(TY), .NUM_CHARS(8)) u1 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof1),
    .pixelX(px), .pixelY(py), .req(ifb),
    .char_code(code1), .row_idx(row1), .col_idx(col1),
    .insideText(ins1)
  );

  typedef struct {
    string       name;
    logic [10:0] x;
    logic [10:0] y;
    logic        ins;
    logic [6:0]  code;
    logic [2:0]  row;
    logic [2:0]  col;
  } pv_t;

  pv_t tbl [8];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(string nm, int x, int y, logic ins,
                     logic [6:0] code, logic [2:0] row, logic [2:0] col);
    px = 11'(x);
    py = 11'(y);
    tick();
    chk({nm, ".inside"}, 32'(ins0), 32'(ins));
    chk({nm, ".code"}, 32'(code0), 32'(code));
    chk({nm, ".row"}, 32'(row0), 32'(row));
    chk({nm, ".col"}, 32'(col0), 32'(col));
  endtask

  task automatic wr_a(string nm, logic [3:0] idx, logic [6:0] ch,
                      logic with_sof);
    ifa.reqA_valid = 1'b1;
    ifa.reqA_idx   = idx;
    ifa.reqA_char  = ch;
    sof0           = with_sof;
    #1;
    chk({nm, ".readyA"}, 32'(ifa.reqA_ready), 32'd1);
    tick();
    ifa.reqA_valid = 1'b0;
    sof0           = 1'b0;
  endtask

  task automatic commit0(string nm, int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s.busyA%0d", nm, k), 32'(ifa.reqA_ready), 32'd0);
      chk($sformatf("%s.busyB%0d", nm, k), 32'(ifa.reqB_ready), 32'd0);
      tick();
    end
    chk({nm, ".doneA"}, 32'(ifa.reqA_ready), 32'd1);
  endtask

  initial begin
    tbl[0] = '{"slot0",  TX,       TY,       1'b1, CH_A,   3'd0, 3'd0};
    tbl[1] = '{"slot1",  TX+15,    TY+7,     1'b1, CH_B,   3'd7, 3'd7};
    tbl[2] = '{"slot2",  TX+16,    TY,       1'b1, CH_5,   3'd0, 3'd0};
    tbl[3] = '{"slot15", TX+127,   TY+7,     1'b1, CH_NUL, 3'd7, 3'd7};
    tbl[4] = '{"left",   TX-1,     TY,       1'b0, CH_NUL, 3'd0, 3'd0};
    tbl[5] = '{"right",  TX+128,   TY,       1'b0, CH_NUL, 3'd0, 3'd0};
    tbl[6] = '{"above",  TX+16,    TY-1,     1'b0, CH_NUL, 3'd0, 3'd0};
    tbl[7] = '{"below",  TX+16,    TY+8,     1'b0, CH_NUL, 3'd0, 3'd0};

    resetN = 1'b0;
    sof0 = 1'b0;
    sof1 = 1'b0;
    px = 11'd0;
    py = 11'd0;
    ifa.reqA_valid = 1'b0; ifa.reqA_idx = '0; ifa.reqA_char = '0;
    ifa.reqB_valid = 1'b0; ifa.reqB_idx = '0; ifa.reqB_char = '0;
    ifb.reqA_valid = 1'b0; ifb.reqA_idx = '0; ifb.reqA_char = '0;
    ifb.reqB_valid = 1'b0; ifb.reqB_idx = '0; ifb.reqB_char = '0;

    repeat (3) tick();
    chk("rst.readyA", 32'(ifa.reqA_ready), 32'd0);
    chk("rst.readyB", 32'(ifa.reqB_ready), 32'd0);
    chk("rst.code", 32'(code0), 32'(CH_NUL));
    chk("rst.inside", 32'(ins0), 32'd0);
    resetN = 1'b1;
    #1;
    chk("idle.readyA", 32'(ifa.reqA_ready), 32'd1);
    chk("idle.readyB", 32'(ifa.reqB_ready), 32'd1);

    pix("p53", TX+5, TY+3, 1'b1, CH_NUL, 3'd3, 3'd5);

    // Contention right after reset: A first, then B.
    ifa.reqA_valid = 1'b1; ifa.reqA_idx = 4'd0; ifa.reqA_char = CH_A;
    ifa.reqB_valid = 1'b1; ifa.reqB_idx = 4'd1; ifa.reqB_char = CH_B;
    #1;
    chk("rr1.readyA", 32'(ifa.reqA_ready), 32'd1);
    chk("rr1.readyB", 32'(ifa.reqB_ready), 32'd0);
    tick();
    ifa.reqA_valid = 1'b0;
    #1;
    chk("rr2.readyB", 32'(ifa.reqB_ready), 32'd1);
    tick();
    ifa.reqB_valid = 1'b0;

    wr_a("w5", 4'd2, CH_5, 1'b0);
    sof0 = 1'b1;
    tick();
    sof0 = 1'b0;
    commit0("cm1", 16);

    for (int i = 0; i < 8; i++)
      pix(tbl[i].name, tbl[i].x, tbl[i].y, tbl[i].ins,
          tbl[i].code, tbl[i].row, tbl[i].col);

    // Clean buffer: startOfFrame must not start a commit.
    sof0 = 1'b1;
    tick();
    sof0 = 1'b0;
    chk("clean.readyA", 32'(ifa.reqA_ready), 32'd1);

    // Reset in the middle of a commit.
    wr_a("w3", 4'd3, CH_C, 1'b0);
    sof0 = 1'b1;
    tick();
    sof0 = 1'b0;
    repeat (4) tick();
    chk("mid.readyA", 32'(ifa.reqA_ready), 32'd0);
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    #1;
    chk("abort.readyA", 32'(ifa.reqA_ready), 32'd1);
    chk("abort.readyB", 32'(ifa.reqB_ready), 32'd1);
    for (int i = 0; i < 16; i++)
      pix($sformatf("clr%0d", i), TX + 8*i, TY, 1'b1, CH_NUL, 3'd0, 3'd0);

    // Write landing with the triggering startOfFrame joins the commit.
    wr_a("w5e", 4'd5, CH_E, 1'b0);
    wr_a("w6f", 4'd6, CH_F, 1'b1);
    commit0("cm2", 16);
    pix("s5", TX+40, TY+2, 1'b1, CH_E, 3'd2, 3'd0);
    pix("s6", TX+49, TY, 1'b1, CH_F, 3'd0, 3'd1);
    pix("s3", TX+24, TY, 1'b1, CH_NUL, 3'd0, 3'd0);

    // 8-slot instance: out-of-range index is accepted and dropped.
    ifb.reqA_valid = 1'b1; ifb.reqA_idx = 4'd15; ifb.reqA_char = CH_Z;
    #1;
    chk("oor.ready", 32'(ifb.reqA_ready), 32'd1);
    tick();
    ifb.reqA_valid = 1'b0;
    sof1 = 1'b1;
    tick();
    sof1 = 1'b0;
    chk("oor.nocommit", 32'(ifb.reqA_ready), 32'd1);
    px = 11'(TX+56);
    py = 11'(TY);
    tick();
    chk("oor.slot7", 32'(code1), 32'(CH_NUL));

    ifb.reqA_valid = 1'b1; ifb.reqA_idx = 4'd7; ifb.reqA_char = CH_Q;
    tick();
    ifb.reqA_valid = 1'b0;
    sof1 = 1'b1;
    tick();
    sof1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("n8.busy%0d", k), 32'(ifb.reqA_ready), 32'd0);
      tick();
    end
    chk("n8.done", 32'(ifb.reqA_ready), 32'd1);
    px = 11'(TX+63);
    py = 11'(TY+1);
    tick();
    chk("n8.code", 32'(code1), 32'(CH_Q));
    chk("n8.col", 32'(col1), 32'd7);
    chk("n8.row", 32'(row1), 32'd1);
    px = 11'(TX+64);
    tick();
    chk("n8.right", 32'(ins1), 32'd0);
    chk("n8.rcode", 32'(code1), 32'(CH_NUL));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
